datagen_sched: RTL and testbench
================================

// Module: datagen_sched
// PURPOSE
//  Run-control sequencer for the datagen sampling/streaming block. Latches a frame config on
//  start, drives datagen's en_sample/frame_size/delay/clr, acknowledges each done, counts
//  completed frames from the AXI-Stream tap, and stops after N frames, on stop, or on timeout.
//  Sits between the AXI-Lite register wrapper and datagen; raises a one-cycle irq at end of run.
// PARAMETERS
//  CNT_W  16  width of frame count config/status (0 = continuous run)
//  TO_W   32  width of watchdog timeout config/counter
// PORTS
//  clk            in   1      single clock domain
//  nrst           in   1      asynchronous, active-low reset
//  start          in   1      pulse: begin run (accepted in IDLE or ERR)
//  stop           in   1      pulse: end run gracefully
//  cfg_frame_size in   8      frame = cfg_frame_size+1 beats
//  cfg_delay      in   32     inter-frame delay, cycles
//  cfg_num_frames in   CNT_W  frames per run; 0 = continuous
//  cfg_timeout    in   TO_W   max cycles between frame ends; 0 = watchdog off
//  dg_en_sample   out  1      to datagen en_sample
//  dg_frame_size  out  8      latched cfg_frame_size
//  dg_delay       out  32     latched cfg_delay
//  dg_clr         out  1      one-cycle done acknowledge
//  dg_done        in   1      from datagen done
//  s_tvalid/s_tready/s_tlast  in 1 each  passive tap of datagen m_axis
//  busy           out  1      state != IDLE
//  frames_done    out  CNT_W  frames completed this run
//  timeout_err    out  1      sticky watchdog flag
//  irq            out  1      one-cycle pulse at run end (normal, stop or timeout)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, latched config 0, counters 0.
//  beat_last = s_tvalid & s_tready & s_tlast; done_rise = dg_done & !done_q.
//  States (2-bit): IDLE, RUN, DRAIN, ERR.
//  IDLE: en_sample=0. start&!stop -> RUN; same edge latch cfg_*, frames_done=0,
//   timeout_err=0, wd_cnt=0. start&stop together -> stay IDLE.
//  RUN: en_sample=1 (registered, asserted cycle after start). start ignored.
//   - done_rise -> dg_clr=1 next cycle, exactly one cycle; in_frame set.
//   - beat_last -> frames_done+1 (wraps), in_frame clear, wd_cnt=0.
//   - beat_last and frames_done+1==cfg_num_frames (nonzero) -> IDLE, en_sample=0 same
//     edge (datagen exits DELAY to IDLE next cycle), irq.
//   - stop & !in_frame -> IDLE, irq; partial sample discarded by datagen.
//   - stop & in_frame -> DRAIN (current frame must finish streaming).
//   - stop & beat_last same cycle -> count frame once, IDLE, irq.
//   - wd_cnt counts every RUN cycle; cfg_timeout!=0 & wd_cnt==cfg_timeout -> ERR.
//  DRAIN: en_sample=0; beat_last -> count frame, IDLE, irq. Watchdog still active -> ERR.
//  ERR: en_sample=0, timeout_err=1 sticky, irq on entry; leave only via start (-> RUN).
//  Watchdog outranks completion if both in one cycle: ERR, frame still counted.
//  dg_frame_size/dg_delay stable whenever en_sample=1; cfg changes mid-run ignored.
//  Reset mid-run: immediate return to IDLE, en_sample=0 drops datagen to IDLE.
// STRUCTURE
//  Package datagen_pkg: state encodings, CNT_W/TO_W defaults, beat-count helper.
//  Sub-module datagen_sched_wdog: TO_W counter with clear/enable/limit -> expire pulse.
//  Top: FSM, config latch, done edge detect + clr pulse, frame counter, irq gen.
// TESTING
//  1 size=3,delay=10,num=2,tready=1 -> two 4-beat frames, 2 clr pulses, frames_done=2, irq once, busy=0.
//  2 num=0, stop at frame 5 mid-stream -> DRAIN, 5th frame completes, frames_done=5, IDLE.
//  3 stop during delay phase, no frame pending -> IDLE next edge, irq, frames_done unchanged.
//  4 timeout=50, tready held 0 -> ERR at wd_cnt==50, timeout_err=1, irq; start -> RUN, err clears.
//  5 start&stop same cycle in IDLE -> busy stays 0; start pulse during RUN -> no effect.
//  6 nrst asserted mid-stream -> all outputs 0 asynchronously; datagen back to IDLE.

Source files
------------

// File: rtl/datagen_sched_pkg.sv
// Shared types and defaults for the datagen run-control sequencer.
package datagen_sched_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int TO_W_DEF  = 32;

  // Sequencer states; the 2-bit code is also visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } sched_state_t;

  // A frame carries frame_size+1 beats on the stream.
  function automatic logic [8:0] frame_beats(input logic [7:0] size);
    return {1'b0, size} + 9'd1;
  endfunction

endpackage

// File: rtl/datagen_sched_if.sv
// Signals between the sequencer and the datagen core.
//
// Handshake rules:
//  - s_tvalid/s_tready/s_tlast are a passive tap of datagen's AXI-Stream
//    output. A beat transfers on a rising clk edge where s_tvalid and s_tready
//    are both high; the beat with s_tlast high ends a frame.
//  - dg_done is raised by datagen when a sample frame is captured and is held
//    until the sequencer returns a single-cycle dg_clr.
//  - dg_en_sample high lets datagen keep sampling; dg_frame_size and dg_delay
//    are stable whenever dg_en_sample is high.
interface datagen_sched_if;

  logic        dg_en_sample;
  logic [7:0]  dg_frame_size;
  logic [31:0] dg_delay;
  logic        dg_clr;
  logic        dg_done;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;

  modport master (
    output dg_en_sample, dg_frame_size, dg_delay, dg_clr,
    input  dg_done, s_tvalid, s_tready, s_tlast
  );

  modport slave (
    input  dg_en_sample, dg_frame_size, dg_delay, dg_clr,
    output dg_done, s_tvalid, s_tready, s_tlast
  );

endinterface

// File: rtl/datagen_sched_wdog.sv
// Watchdog counter: counts enabled cycles since the last clear and flags
// expiry when the count reaches a nonzero limit.
module datagen_sched_wdog
  import datagen_sched_pkg::*;
#(
  parameter int TO_W = TO_W_DEF
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] limit,
  output logic            expire
);

  logic [TO_W-1:0] cnt;

  // Cycle counter; clear wins over count so a frame end restarts the window.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  // A zero limit disables the watchdog entirely.
  assign expire = en && (limit != '0) && (cnt == limit);

endmodule

// File: rtl/datagen_sched.sv
// Run-control sequencer for datagen: latches the frame config on start,
// enables sampling, acknowledges done, counts streamed frames and ends the
// run after N frames, on stop, or on watchdog timeout.
module datagen_sched
  import datagen_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TO_W  = TO_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        cfg_frame_size,
  input  logic [31:0]       cfg_delay,
  input  logic [CNT_W-1:0]  cfg_num_frames,
  input  logic [TO_W-1:0]   cfg_timeout,
  datagen_sched_if.master   dg,
  output logic              busy,
  output logic [CNT_W-1:0]  frames_done,
  output logic              timeout_err,
  output logic              irq,
  output sched_state_t      state_dbg
);

  sched_state_t     state_q;
  sched_state_t     state_d;
  logic [CNT_W-1:0] num_q;
  logic [TO_W-1:0]  timeout_q;
  logic             done_q;
  logic             in_frame;
  logic             wd_expire;

  logic             beat_last;
  logic             done_rise;
  logic             counting;
  logic             frame_end;
  logic             start_ok;
  logic [CNT_W-1:0] frames_next;
  logic             last_of_run;

  assign beat_last   = dg.s_tvalid & dg.s_tready & dg.s_tlast;
  assign done_rise   = dg.dg_done & ~done_q;
  assign counting    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign frame_end   = counting && beat_last;
  assign frames_next = frames_done + CNT_W'(1);
  assign last_of_run = (num_q != '0) && (frames_next == num_q);
  // A run is (re)started only by entering RUN from IDLE or ERR.
  assign start_ok    = (state_q == ST_IDLE || state_q == ST_ERR) && (state_d == ST_RUN);

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

  datagen_sched_wdog #(.TO_W(TO_W)) u_wdog (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (start_ok | frame_end),
    .en     (counting),
    .limit  (timeout_q),
    .expire (wd_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; watchdog expiry outranks every other exit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wd_expire)                        state_d = ST_ERR;
        else if (beat_last && last_of_run)    state_d = ST_IDLE;
        else if (stop && (beat_last || !in_frame)) state_d = ST_IDLE;
        else if (stop)                        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wd_expire)      state_d = ST_ERR;
        else if (beat_last) state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Config latch and sample enable; config only moves on an accepted start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dg.dg_en_sample  <= 1'b0;
      dg.dg_frame_size <= '0;
      dg.dg_delay      <= '0;
      num_q            <= '0;
      timeout_q        <= '0;
    end else begin
      dg.dg_en_sample <= (state_d == ST_RUN);
      if (start_ok) begin
        dg.dg_frame_size <= cfg_frame_size;
        dg.dg_delay      <= cfg_delay;
        num_q            <= cfg_num_frames;
        timeout_q        <= cfg_timeout;
      end
    end
  end

  // Done edge detect, single-cycle acknowledge and in-frame tracking.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done_q   <= 1'b0;
      dg.dg_clr <= 1'b0;
      in_frame <= 1'b0;
    end else begin
      done_q    <= dg.dg_done;
      dg.dg_clr <= (state_q == ST_RUN) && done_rise;
      if (start_ok)                            in_frame <= 1'b0;
      else if ((state_q == ST_RUN) && done_rise) in_frame <= 1'b1;
      else if (frame_end)                      in_frame <= 1'b0;
    end
  end

  // Frame counter, sticky timeout flag and end-of-run interrupt.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frames_done <= '0;
      timeout_err <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (start_ok)       frames_done <= '0;
      else if (frame_end) frames_done <= frames_next;
      if (start_ok)                timeout_err <= 1'b0;
      else if (state_d == ST_ERR)  timeout_err <= 1'b1;
      irq <= ((state_q != ST_IDLE) && (state_d == ST_IDLE)) ||
             ((state_q != ST_ERR)  && (state_d == ST_ERR));
    end
  end

endmodule

// File: tb/tb_datagen_sched.sv
// Bench for datagen_sched: table of run scenarios, randomized runs checked
// against a frame-count model, and hand sequences for timeout/reset corners.
module tb_datagen_sched;
  import datagen_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic        start, stop;
  logic [7:0]  cfg_frame_size;
  logic [31:0] cfg_delay;
  logic [15:0] cfg_num_frames;
  logic [31:0] cfg_timeout;
  logic        busy, timeout_err, irq;
  logic [15:0] frames_done;
  sched_state_t state_dbg;

  datagen_sched_if dg_if ();

  datagen_sched #(.CNT_W(16), .TO_W(32)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start          (start),
    .stop           (stop),
    .cfg_frame_size (cfg_frame_size),
    .cfg_delay      (cfg_delay),
    .cfg_num_frames (cfg_num_frames),
    .cfg_timeout    (cfg_timeout),
    .dg             (dg_if),
    .busy           (busy),
    .frames_done    (frames_done),
    .timeout_err    (timeout_err),
    .irq            (irq),
    .state_dbg      (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int irq_total = 0;
  int clr_total = 0;
  logic prev_clr = 1'b0;
  logic [7:0]  cur_size;
  logic [31:0] cur_delay;

  typedef struct {
    int size;
    int delay;
    int num;
    int timeout;
    int stop_frame;   // -1: no stop
    bit stop_mid;     // stop while the frame is streaming
    int exp_frames;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frames a run should complete, from the run rules alone.
  function automatic int model_frames(input int num, input int stop_frame, input bit stop_mid);
    if (stop_frame < 0 || (num != 0 && stop_frame >= num)) return num;
    return stop_mid ? stop_frame + 1 : stop_frame;
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one cycle; sample 1 ns after the edge and watch pulse outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (dg_if.dg_clr) begin
      clr_total++;
      chk("clr_one_cycle", prev_clr, 1'b0);
    end
    prev_clr = dg_if.dg_clr;
    if (irq) irq_total++;
    if (dg_if.dg_en_sample) begin
      chk("hold_size", dg_if.dg_frame_size, cur_size);
      chk("hold_delay", dg_if.dg_delay, cur_delay);
    end
  endtask

  task automatic apply_cfg(input int size, input int delay, input int num, input int timeout);
    cfg_frame_size = 8'(size);
    cfg_delay      = 32'(delay);
    cfg_num_frames = 16'(num);
    cfg_timeout    = 32'(timeout);
    cur_size       = 8'(size);
    cur_delay      = 32'(delay);
  endtask

  // Start pulse, then scramble the config inputs: the run must ignore them.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_frame_size = 8'($urandom);
    cfg_delay      = $urandom;
    cfg_num_frames = 16'($urandom);
    cfg_timeout    = $urandom_range(1, 3);
  endtask

  task automatic send_done();
    bit seen = 1'b0;
    dg_if.dg_done = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (dg_if.dg_clr) seen = 1'b1;
    end
    dg_if.dg_done = 1'b0;
    chk("clr_ack", seen, 1'b1);
  endtask

  task automatic stream(input int beats, input int stop_after);
    for (int b = 0; b < beats; b++) begin
      if (b == stop_after) begin
        dg_if.s_tvalid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("drain_state", state_dbg, ST_DRAIN);
        chk("drain_en", dg_if.dg_en_sample, 1'b0);
        chk("drain_busy", busy, 1'b1);
      end
      dg_if.s_tvalid = 1'b1;
      dg_if.s_tlast  = (b == beats - 1);
      dg_if.s_tready = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      dg_if.s_tready = 1'b1;
      tick();
    end
    dg_if.s_tvalid = 1'b0;
    dg_if.s_tready = 1'b0;
    dg_if.s_tlast  = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    logic [15:0] exp_q[$];
    int base_irq = irq_total;
    int base_clr = clr_total;
    int f = 0;
    bit fin = 1'b0;
    apply_cfg(v.size, v.delay, v.num, v.timeout);
    pulse_start();
    chk("start_busy", busy, 1'b1);
    chk("start_en", dg_if.dg_en_sample, 1'b1);
    chk("start_frames", frames_done, 16'd0);
    while (!fin) begin
      repeat ($urandom_range(0, 3)) tick();
      if (v.stop_frame == f && !v.stop_mid) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        fin = 1'b1;
      end else begin
        exp_q.push_back(16'(f + 1));
        send_done();
        stream(v.size + 1, (v.stop_frame == f) ? 2 : -1);
        chk("frame_count", frames_done, exp_q.pop_front());
        f++;
        if (v.stop_frame == f - 1 || (v.num != 0 && f == v.num)) fin = 1'b1;
        if (!fin && f > 40) begin
          chk("run_bound", busy, 1'b0);
          fin = 1'b1;
        end
      end
    end
    chk("end_irq", irq, 1'b1);
    chk("end_busy", busy, 1'b0);
    chk("end_en", dg_if.dg_en_sample, 1'b0);
    chk("end_frames", frames_done, 16'(v.exp_frames));
    tick();
    tick();
    chk("irq_count", irq_total - base_irq, 1);
    chk("clr_count", clr_total - base_clr, v.exp_frames);
    chk("frames_hold", frames_done, 16'(v.exp_frames));
    chk("irq_low", irq, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // size, delay, num, timeout, stop_frame, stop_mid, exp_frames
    vecs[0] = '{3, 10, 2, 0,   -1, 1'b0, 2};
    vecs[1] = '{0, 5,  1, 0,   -1, 1'b0, 1};
    vecs[2] = '{7, 0,  3, 200, -1, 1'b0, 3};
    vecs[3] = '{3, 20, 0, 0,    4, 1'b1, 5};
    vecs[4] = '{1, 8,  0, 0,    2, 1'b0, 2};
    vecs[5] = '{2, 3,  4, 0,    1, 1'b0, 1};

    nrst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    apply_cfg(0, 0, 0, 0);
    dg_if.dg_done  = 1'b0;
    dg_if.s_tvalid = 1'b0;
    dg_if.s_tready = 1'b0;
    dg_if.s_tlast  = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_en", dg_if.dg_en_sample, 1'b0);
    chk("rst_clr", dg_if.dg_clr, 1'b0);
    chk("rst_frames", frames_done, 16'd0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_size", dg_if.dg_frame_size, 8'd0);
    chk("rst_delay", dg_if.dg_delay, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_case(vecs[i]);

    for (int r = 0; r < 8; r++) begin
      vec_t rv;
      rv.size       = $urandom_range(0, 5);
      rv.delay      = $urandom_range(0, 100);
      rv.num        = $urandom_range(1, 4);
      rv.timeout    = ($urandom_range(0, 1) == 1) ? 500 : 0;
      rv.stop_frame = $urandom_range(0, 5);
      rv.stop_mid   = (rv.size >= 2) && ($urandom_range(0, 1) == 1);
      rv.exp_frames = model_frames(rv.num, rv.stop_frame, rv.stop_mid);
      run_case(rv);
    end

    // start and stop together in IDLE: no run
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", busy, 1'b0);
    chk("ss_en", dg_if.dg_en_sample, 1'b0);
    chk("ss_irq", irq, 1'b0);

    // start pulse during RUN is ignored
    apply_cfg(1, 4, 1, 0);
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rerun_state", state_dbg, ST_RUN);
    chk("rerun_frames", frames_done, 16'd0);
    send_done();
    stream(2, -1);
    chk("rerun_end_busy", busy, 1'b0);
    chk("rerun_end_frames", frames_done, 16'd1);
    chk("rerun_end_irq", irq, 1'b1);

    // watchdog: stalled stream, expiry when the count reaches 50
    apply_cfg(2, 0, 0, 50);
    pulse_start();
    dg_if.dg_done  = 1'b1;
    dg_if.s_tvalid = 1'b1;
    dg_if.s_tready = 1'b0;
    repeat (50) tick();
    chk("wd_pre_state", state_dbg, ST_RUN);
    chk("wd_pre_terr", timeout_err, 1'b0);
    tick();
    chk("wd_state", state_dbg, ST_ERR);
    chk("wd_terr", timeout_err, 1'b1);
    chk("wd_irq", irq, 1'b1);
    chk("wd_en", dg_if.dg_en_sample, 1'b0);
    chk("wd_busy", busy, 1'b1);
    dg_if.dg_done  = 1'b0;
    dg_if.s_tvalid = 1'b0;
    tick();
    chk("wd_sticky", timeout_err, 1'b1);
    chk("wd_irq_once", irq, 1'b0);
    chk("wd_hold_err", state_dbg, ST_ERR);
    apply_cfg(2, 0, 0, 0);
    pulse_start();
    chk("err_restart", state_dbg, ST_RUN);
    chk("err_cleared", timeout_err, 1'b0);
    chk("err_restart_en", dg_if.dg_en_sample, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("err_stop_idle", state_dbg, ST_IDLE);
    chk("err_stop_irq", irq, 1'b1);

    // watchdog expiry and the final beat in the same cycle
    apply_cfg(0, 0, 1, 50);
    pulse_start();
    repeat (50) tick();
    dg_if.s_tvalid = 1'b1;
    dg_if.s_tready = 1'b1;
    dg_if.s_tlast  = 1'b1;
    tick();
    dg_if.s_tvalid = 1'b0;
    dg_if.s_tready = 1'b0;
    dg_if.s_tlast  = 1'b0;
    chk("tie_state", state_dbg, ST_ERR);
    chk("tie_frames", frames_done, 16'd1);
    chk("tie_terr", timeout_err, 1'b1);
    chk("tie_irq", irq, 1'b1);

    // asynchronous reset in the middle of a frame
    apply_cfg(1, 2, 0, 0);
    pulse_start();
    send_done();
    stream(2, -1);
    chk("pre_rst_frames", frames_done, 16'd1);
    send_done();
    dg_if.s_tvalid = 1'b1;
    dg_if.s_tready = 1'b1;
    tick();
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_en", dg_if.dg_en_sample, 1'b0);
    chk("arst_clr", dg_if.dg_clr, 1'b0);
    chk("arst_frames", frames_done, 16'd0);
    chk("arst_terr", timeout_err, 1'b0);
    chk("arst_irq", irq, 1'b0);
    chk("arst_size", dg_if.dg_frame_size, 8'd0);
    chk("arst_delay", dg_if.dg_delay, 32'd0);
    dg_if.s_tvalid = 1'b0;
    dg_if.s_tready = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    tick();
    chk("post_rst_state", state_dbg, ST_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
